// File: rtl/mem_access_unit_if.sv
// Signal bundle between the M-stage load/store unit, the pipeline control and the data-memory port.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_we;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                flush;
  logic                stall;
  logic                done;
  logic [DATA_W-1:0]   rdata;
  logic                adel;
  logic                ades;
  logic [ADDR_W-1:0]   bad_addr;
  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  // master: pipeline plus memory environment; slave: the load/store unit itself
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, flush,
    output mem_ack, mem_rdata,
    input  stall, done, rdata, adel, ades, bad_addr,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, flush,
    input  mem_ack, mem_rdata,
    output stall, done, rdata, adel, ades, bad_addr,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: byte-lane enables, store replication, load extraction/extension,
// alignment exceptions and a variable-latency req/ack handshake with flush abort.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);
  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  logic [1:0]        state;
  logic              memReqQ;
  logic              memWeQ;
  logic              doneQ;
  logic [NB-1:0]     memBeQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [DATA_W-1:0] memWdataQ;
  logic [DATA_W-1:0] rdataQ;
  logic [1:0]        sizeQ;
  logic              signedQ;
  logic [LANE_W-1:0] laneQ;

  logic [LANE_W-1:0] lane;
  logic              misaligned;
  logic              addrErr;
  logic              accept;
  logic              stallC;

  function automatic logic [NB-1:0] byteEnables(input logic [1:0] size, input logic [LANE_W-1:0] ln);
    case (size)
      2'd0:    return NB'(1) << ln;
      2'd1:    return NB'(2'b11) << ln;
      2'd2:    return NB'(4'hF) << ln;
      default: return '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size, input logic [DATA_W-1:0] wd);
    case (size)
      2'd0:    return {NB{wd[7:0]}};
      2'd1:    return {(DATA_W/16){wd[15:0]}};
      2'd2:    return {(DATA_W/32){wd[31:0]}};
      default: return wd;
    endcase
  endfunction

  // Shift the addressed field down to bit 0, then widen it by sign or zero.
  function automatic logic [DATA_W-1:0] extendLoad(input logic [DATA_W-1:0] word, input logic [1:0] size,
                                                   input logic sgn, input logic [LANE_W-1:0] ln);
    logic [DATA_W-1:0]        shifted;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [31:0]       w;
    logic signed [DATA_W-1:0] ext;
    shifted = word >> {ln, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    w = shifted[31:0];
    case (size)
      2'd0: begin
        ext = DATA_W'(shifted[7:0]);
        if (sgn) ext = DATA_W'(b);
      end
      2'd1: begin
        ext = DATA_W'(shifted[15:0]);
        if (sgn) ext = DATA_W'(h);
      end
      2'd2: begin
        ext = DATA_W'(shifted[31:0]);
        if (sgn) ext = DATA_W'(w);
      end
      default: ext = shifted;
    endcase
    return ext;
  endfunction

  assign lane = bus.req_addr[LANE_W-1:0];

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      2'd3:    misaligned = (DATA_W == 32) || (|bus.req_addr[2:0]);
      default: misaligned = 1'b0;
    endcase
  end

  assign addrErr = (state == IDLE) && bus.req_valid && misaligned;
  assign accept  = (state == IDLE) && bus.req_valid && !misaligned && !bus.flush;

  always_comb begin
    stallC = 1'b0;
    case (state)
      IDLE:    stallC = accept;
      BUSY:    stallC = 1'b1;
      ABORT:   stallC = bus.req_valid;
      default: stallC = 1'b0;
    endcase
  end

  assign bus.stall     = stallC;
  assign bus.adel      = addrErr && !bus.req_we;
  assign bus.ades      = addrErr && bus.req_we;
  assign bus.bad_addr  = addrErr ? bus.req_addr : '0;
  assign bus.done      = doneQ;
  assign bus.rdata     = rdataQ;
  assign bus.mem_req   = memReqQ;
  assign bus.mem_we    = memWeQ;
  assign bus.mem_be    = memBeQ;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;

  // Request capture / memory handshake stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      doneQ     <= 1'b0;
      memBeQ    <= '0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      rdataQ    <= '0;
      sizeQ     <= '0;
      signedQ   <= 1'b0;
      laneQ     <= '0;
    end else begin
      doneQ <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            memReqQ   <= 1'b1;
            memWeQ    <= bus.req_we;
            memBeQ    <= bus.req_we ? byteEnables(bus.req_size, lane) : '0;
            memAddrQ  <= {bus.req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
            memWdataQ <= replicate(bus.req_size, bus.req_wdata);
            sizeQ     <= bus.req_size;
            signedQ   <= bus.req_signed;
            laneQ     <= lane;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            memReqQ <= 1'b0;
            if (bus.flush) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              doneQ <= 1'b1;
              if (!memWeQ) rdataQ <= extendLoad(bus.mem_rdata, sizeQ, signedQ, laneQ);
            end
          end else if (bus.flush) begin
            state <= ABORT;
          end
        end
        DONE: state <= IDLE;
        // An issued transaction is never withdrawn; wait out its ack and discard it.
        ABORT: begin
          if (bus.mem_ack) begin
            memReqQ <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
